// File: rtl/ldpc_pkg.sv
// Shared defaults and FSM state encoding for the LDPC variable-node update block.
package ldpc_pkg;

  localparam int LLR_WIDTH_DEF  = 8;
  localparam int ROW_WEIGHT_DEF = 24;
  localparam int NUM_ROWS_DEF   = 4;
  localparam int ACC_WIDTH_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } vnu_state_t;

endpackage

// File: rtl/ldpc_vnu_sat_add.sv
// One variable-node column: expands a compressed check message, adds it with saturation.
// Define LDPC_VNU_NMS_EN to scale each expanded magnitude by 0.75 (normalized min-sum).
module ldpc_vnu_sat_add
  import ldpc_pkg::*;
#(
  parameter int LLR_WIDTH = LLR_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LLR_WIDTH-1:0] ch_llr,
  input  logic                 add_en,
  input  logic [LLR_WIDTH-2:0] mag_min,
  input  logic [LLR_WIDTH-2:0] mag_submin,
  input  logic                 use_submin,
  input  logic                 neg,
  output logic [LLR_WIDTH-1:0] app_llr,
  output logic                 hard_dec
);

  localparam int MW = LLR_WIDTH - 1;
  localparam logic signed [ACC_WIDTH:0] SAT_POS = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_NEG = -SAT_POS;
  localparam logic [ACC_WIDTH-1:0]      MAG_MAX = {{(ACC_WIDTH-MW){1'b0}}, {MW{1'b1}}};

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_load;
  logic signed [ACC_WIDTH-1:0] ch_ext;
  logic        [MW-1:0]        mag_sel;
  logic        [MW-1:0]        mag_scaled;
  logic signed [ACC_WIDTH:0]   mag_ext;
  logic signed [ACC_WIDTH:0]   delta;
  logic signed [ACC_WIDTH:0]   acc_ext;
  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic        [ACC_WIDTH-1:0] acc_abs;
  logic        [MW-1:0]        mag_out;

  always_comb begin
    ch_ext   = {{(ACC_WIDTH-MW){1'b0}}, ch_llr[MW-1:0]};
    acc_load = ch_llr[LLR_WIDTH-1] ? -ch_ext : ch_ext;

    mag_sel = use_submin ? mag_submin : mag_min;
`ifdef LDPC_VNU_NMS_EN
    mag_scaled = mag_sel - (mag_sel >> 2);
`else
    mag_scaled = mag_sel;
`endif
    mag_ext = {{(ACC_WIDTH+1-MW){1'b0}}, mag_scaled};
    delta   = neg ? -mag_ext : mag_ext;

    // One guard bit makes overflow detection a plain signed range compare.
    acc_ext = {acc[ACC_WIDTH-1], acc};
    sum     = acc_ext + delta;
    if (sum > SAT_POS)
      acc_sum = SAT_POS[ACC_WIDTH-1:0];
    else if (sum < SAT_NEG)
      acc_sum = SAT_NEG[ACC_WIDTH-1:0];
    else
      acc_sum = sum[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (load)
      acc <= acc_load;
    else if (add_en)
      acc <= acc_sum;
  end

  // Zero converts to +0 naturally since the sign comes from the two's-complement MSB.
  always_comb begin
    acc_abs  = acc[ACC_WIDTH-1] ? -acc : acc;
    mag_out  = (acc_abs > MAG_MAX) ? MAG_MAX[MW-1:0] : acc_abs[MW-1:0];
    app_llr  = {acc[ACC_WIDTH-1], mag_out};
    hard_dec = acc[ACC_WIDTH-1];
  end

endmodule

// File: rtl/ldpc_vnu.sv
// LDPC variable-node update: accumulates NUM_ROWS check messages onto channel LLRs per frame.
module ldpc_vnu
  import ldpc_pkg::*;
#(
  parameter int LLR_WIDTH  = LLR_WIDTH_DEF,
  parameter int ROW_WEIGHT = ROW_WEIGHT_DEF,
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ROW_WEIGHT*LLR_WIDTH-1:0] ch_llr,
  input  logic                            c2v_valid,
  output logic                            c2v_ready,
  input  logic [LLR_WIDTH-2:0]            c2v_min,
  input  logic [LLR_WIDTH-2:0]            c2v_submin,
  input  logic [4:0]                      c2v_min_idx,
  input  logic [ROW_WEIGHT-1:0]           c2v_sign,
  input  logic [1:0]                      c2v_row,
  output logic                            app_valid,
  input  logic                            app_ready,
  output logic [ROW_WEIGHT*LLR_WIDTH-1:0] app_llr,
  output logic [ROW_WEIGHT-1:0]           hard_dec,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int CNT_W = $clog2(NUM_ROWS + 1);

  vnu_state_t       state, state_nxt;
  logic [3:0]       row_seen;
  logic [CNT_W-1:0] row_cnt;
  logic             load;
  logic             accept;
  logic             dup;
  logic             add_en;
  logic             last_row;

  always_comb begin
    c2v_ready = (state == ACCUM);
    app_valid = (state == OUTPUT);
    busy      = (state != IDLE);
    load      = start && (state == IDLE);
    accept    = c2v_valid && c2v_ready;
    dup       = row_seen[c2v_row];
    add_en    = accept && !dup;
    last_row  = add_en && (row_cnt == CNT_W'(NUM_ROWS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ACCUM;
      ACCUM:   if (last_row)  state_nxt = OUTPUT;
      OUTPUT:  if (app_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_seen <= '0;
      row_cnt  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == OUTPUT) && app_ready;
      if (load) begin
        row_seen <= '0;
        row_cnt  <= '0;
        err      <= 1'b0;
      end else if (accept) begin
        if (dup) begin
          err <= 1'b1;
        end else begin
          row_seen[c2v_row] <= 1'b1;
          row_cnt           <= row_cnt + CNT_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < ROW_WEIGHT; k++) begin : g_col
    logic use_sub;
    // An out-of-range min_idx never matches any column, so all columns take c2v_min.
    assign use_sub = (int'(c2v_min_idx) == k);

    ldpc_vnu_sat_add #(
      .LLR_WIDTH(LLR_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_col (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .ch_llr     (ch_llr[k*LLR_WIDTH +: LLR_WIDTH]),
      .add_en     (add_en),
      .mag_min    (c2v_min),
      .mag_submin (c2v_submin),
      .use_submin (use_sub),
      .neg        (c2v_sign[k]),
      .app_llr    (app_llr[k*LLR_WIDTH +: LLR_WIDTH]),
      .hard_dec   (hard_dec[k])
    );
  end

endmodule

// File: tb/tb_ldpc_vnu.sv
// Directed self-checking bench for ldpc_vnu; expectations are hand-computed per scenario.
module tb_ldpc_vnu;

  localparam int LW = 8;
  localparam int RW = 24;
  localparam int NR = 4;
  localparam int AW = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [RW*LW-1:0] ch_llr = '0;
  logic           c2v_valid = 1'b0;
  logic           c2v_ready;
  logic [LW-2:0]  c2v_min = '0;
  logic [LW-2:0]  c2v_submin = '0;
  logic [4:0]     c2v_min_idx = '0;
  logic [RW-1:0]  c2v_sign = '0;
  logic [1:0]     c2v_row = '0;
  logic           app_valid;
  logic           app_ready = 1'b0;
  logic [RW*LW-1:0] app_llr;
  logic [RW-1:0]  hard_dec;
  logic           busy, done, err;

  int unsigned checks = 0;
  int unsigned failures = 0;

  ldpc_vnu #(
    .LLR_WIDTH (LW),
    .ROW_WEIGHT(RW),
    .NUM_ROWS  (NR),
    .ACC_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ch_llr     (ch_llr),
    .c2v_valid  (c2v_valid),
    .c2v_ready  (c2v_ready),
    .c2v_min    (c2v_min),
    .c2v_submin (c2v_submin),
    .c2v_min_idx(c2v_min_idx),
    .c2v_sign   (c2v_sign),
    .c2v_row    (c2v_row),
    .app_valid  (app_valid),
    .app_ready  (app_ready),
    .app_llr    (app_llr),
    .hard_dec   (hard_dec),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW*LW-1:0] fill(input logic [LW-1:0] v);
    logic [RW*LW-1:0] r;
    for (int k = 0; k < RW; k++) r[k*LW +: LW] = v;
    return r;
  endfunction

  task automatic begin_frame(input logic [LW-1:0] ch);
    ch_llr = fill(ch);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic send_row(input logic [1:0] row, input logic [6:0] mn, input logic [6:0] sub,
                          input logic [4:0] idx, input logic [RW-1:0] sg);
    int unsigned n;
    n = 0;
    c2v_valid = 1'b1; c2v_row = row; c2v_min = mn; c2v_submin = sub;
    c2v_min_idx = idx; c2v_sign = sg;
    while (!c2v_ready && n < 20) begin
      tick();
      n++;
    end
    if (!c2v_ready) begin
      checks++; failures++;
      $display("FAIL c2v_ready_timeout row=%0d got=%b exp=1", row, c2v_ready);
    end
    tick();
    c2v_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name);
    app_ready = 1'b1;
    tick();
    app_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done got done=%b busy=%b exp done=1 busy=0", name, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse got=%b exp=0", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (app_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || c2v_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got v=%b b=%b d=%b e=%b r=%b exp all 0", app_valid, busy, done, err, c2v_ready);
    end
    checks++;
    if (app_llr !== '0 || hard_dec !== '0) begin
      failures++;
      $display("FAIL reset_data got llr=%h hd=%h exp 0", app_llr, hard_dec);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [RW*LW-1:0] exp_llr;
    logic [LW-1:0] col2;
`ifdef LDPC_VNU_NMS_EN
    col2 = 8'h21;
`else
    col2 = 8'h29;
`endif
    exp_llr = fill(8'h11);
    exp_llr[2*LW +: LW] = col2;
    begin_frame(8'h05);
    checks++;
    if (busy !== 1'b1 || c2v_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got busy=%b ready=%b exp 1 1", busy, c2v_ready);
    end
    for (int r = 0; r < NR; r++) send_row(2'(r), 7'd3, 7'd9, 5'd2, '0);
    checks++;
    if (app_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_valid got=%b exp=1", app_valid);
    end
    checks++;
    if (app_llr !== exp_llr || hard_dec !== '0) begin
      failures++;
      $display("FAIL basic_llr got=%h hd=%h exp=%h hd=0", app_llr, hard_dec, exp_llr);
    end
    finish_frame("basic");
  endtask

  task automatic test_saturate();
    begin_frame(8'h7F);
    for (int r = 0; r < NR; r++) send_row(2'(r), 7'd127, 7'd127, 5'd0, '0);
    checks++;
    if (app_llr !== fill(8'h7F) || hard_dec !== '0 || dut.g_col[5].u_col.acc !== 10'sd511) begin
      failures++;
      $display("FAIL sat_pos got=%h hd=%h acc=%0d exp 7f.. hd=0 acc=511", app_llr, hard_dec,
               dut.g_col[5].u_col.acc);
    end
    finish_frame("sat_pos");
    begin_frame(8'hFF);
    for (int r = 0; r < NR; r++) send_row(2'(r), 7'd127, 7'd127, 5'd0, '1);
    checks++;
    if (app_llr !== fill(8'hFF) || hard_dec !== '1 || dut.g_col[5].u_col.acc !== -10'sd511) begin
      failures++;
      $display("FAIL sat_neg got=%h hd=%h acc=%0d exp ff.. hd=ffffff acc=-511", app_llr, hard_dec,
               dut.g_col[5].u_col.acc);
    end
    finish_frame("sat_neg");
  endtask

  task automatic test_negative();
    begin_frame(8'h83);
    send_row(2'd0, 7'd2, 7'd0, 5'd31, '1);
    for (int r = 1; r < NR; r++) send_row(2'(r), 7'd0, 7'd0, 5'd31, '0);
    checks++;
    if (app_llr !== fill(8'h85) || hard_dec !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL negative got=%h hd=%h exp 85.. hd=ffffff", app_llr, hard_dec);
    end
    finish_frame("negative");
  endtask

  task automatic test_zero_sign();
    begin_frame(8'h81);
    send_row(2'd0, 7'd1, 7'd1, 5'd0, '0);
    for (int r = 1; r < NR; r++) send_row(2'(r), 7'd0, 7'd0, 5'd0, '0);
    checks++;
    if (app_llr !== '0 || hard_dec !== '0) begin
      failures++;
      $display("FAIL zero_sign got=%h hd=%h exp 0", app_llr, hard_dec);
    end
    finish_frame("zero");
  endtask

  task automatic test_duplicate();
    begin_frame(8'h00);
    send_row(2'd1, 7'd1, 7'd1, 5'd31, '0);
    send_row(2'd1, 7'd1, 7'd1, 5'd31, '0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL dup_err got=%b exp=1", err);
    end
    send_row(2'd0, 7'd1, 7'd1, 5'd31, '0);
    send_row(2'd2, 7'd1, 7'd1, 5'd31, '0);
    checks++;
    if (app_valid !== 1'b0) begin
      failures++;
      $display("FAIL dup_early_valid got=%b exp=0", app_valid);
    end
    // start while ACCUM must be ignored
    ch_llr = fill(8'h7F); start = 1'b1;
    tick();
    start = 1'b0;
    send_row(2'd3, 7'd1, 7'd1, 5'd31, '0);
    checks++;
    if (app_valid !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL dup_valid got v=%b e=%b exp 1 1", app_valid, err);
    end
    checks++;
    if (app_llr !== fill(8'h04) || hard_dec !== '0) begin
      failures++;
      $display("FAIL dup_llr got=%h exp 04..", app_llr);
    end
    finish_frame("dup");
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL dup_err_sticky got=%b exp=1", err);
    end
  endtask

  task automatic test_backpressure();
    logic [RW*LW-1:0] exp_llr;
    logic [LW-1:0] col0;
`ifdef LDPC_VNU_NMS_EN
    col0 = 8'h11;
`else
    col0 = 8'h15;
`endif
    for (int k = 0; k < RW; k++) exp_llr[k*LW +: LW] = (k % 2 == 1) ? 8'h83 : 8'h0D;
    exp_llr[LW-1:0] = col0;
    begin_frame(8'h05);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL start_clears_err got=%b exp=0", err);
    end
    for (int r = 0; r < NR; r++) send_row(2'(r), 7'd2, 7'd4, 5'd0, 24'hAAAAAA);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (app_valid !== 1'b1 || app_llr !== exp_llr || hard_dec !== 24'hAAAAAA || done !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold c=%0d got v=%b d=%b llr=%h hd=%h exp v=1 d=0 llr=%h hd=aaaaaa",
                 c, app_valid, done, app_llr, hard_dec, exp_llr);
      end
    end
    finish_frame("bp");
  endtask

  task automatic test_mid_reset();
    logic [RW*LW-1:0] exp_llr;
    begin_frame(8'h22);
    send_row(2'd0, 7'd5, 7'd5, 5'd0, '0);
    send_row(2'd0, 7'd5, 7'd5, 5'd0, '0);
    send_row(2'd1, 7'd5, 7'd5, 5'd0, '0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (app_llr !== '0 || hard_dec !== '0 || busy !== 1'b0 || app_valid !== 1'b0 ||
        err !== 1'b0 || done !== 1'b0 || c2v_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got llr=%h hd=%h b=%b v=%b e=%b d=%b r=%b exp all 0",
               app_llr, hard_dec, busy, app_valid, err, done, c2v_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    exp_llr = fill(8'h11);
`ifdef LDPC_VNU_NMS_EN
    exp_llr[2*LW +: LW] = 8'h21;
`else
    exp_llr[2*LW +: LW] = 8'h29;
`endif
    begin_frame(8'h05);
    for (int r = 0; r < NR; r++) send_row(2'(r), 7'd3, 7'd9, 5'd2, '0);
    checks++;
    if (app_valid !== 1'b1 || app_llr !== exp_llr) begin
      failures++;
      $display("FAIL post_reset_frame got v=%b llr=%h exp v=1 llr=%h", app_valid, app_llr, exp_llr);
    end
    finish_frame("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_negative();
    test_zero_sign();
    test_duplicate();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/ldpc_vnu.md
LDPC_VNU -- requirements
Module: ldpc_vnu

Interface
REQ-001 Parameter LLR_WIDTH, default 8, sign-magnitude LLR width (bit MSB = sign, 1 = negative; rest = magnitude).
REQ-002 Parameter ROW_WEIGHT, default 24, variable nodes per column block.
REQ-003 Parameter NUM_ROWS, default 4, check rows combined per frame.
REQ-004 Parameter ACC_WIDTH, default 10, two's-complement accumulator width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; loads ch_llr, begins a frame.
REQ-008 ch_llr  in  ROW_WEIGHT*LLR_WIDTH  channel LLRs; column k at bits [k*LLR_WIDTH +: LLR_WIDTH].
REQ-009 c2v_valid / c2v_ready  in / out  1 each  check-to-variable message handshake.
REQ-010 c2v_min, c2v_submin  in  LLR_WIDTH-1 each  compressed check-node magnitudes.
REQ-011 c2v_min_idx  in  5  column holding the minimum.
REQ-012 c2v_sign  in  ROW_WEIGHT  outgoing sign per column (1 = negative).
REQ-013 c2v_row  in  2  check row index of the message.
REQ-014 app_valid / app_ready  out / in  1 each  posterior output handshake.
REQ-015 app_llr  out  ROW_WEIGHT*LLR_WIDTH  posterior LLRs, sign-magnitude, same packing as ch_llr.
REQ-016 hard_dec  out  ROW_WEIGHT  hard decisions (1 = negative LLR).
REQ-017 busy, done, err  out  1 each  frame active; one-cycle completion pulse; sticky duplicate-row flag.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM, OUTPUT.
REQ-019 In IDLE, start SHALL load each accumulator with the sign-extended ch_llr column and move to ACCUM on the next edge; start outside IDLE SHALL be ignored.
REQ-020 c2v_ready SHALL be 1 only in ACCUM; a message is accepted when c2v_valid & c2v_ready.
REQ-021 Per accepted message, column k SHALL add magnitude (k == c2v_min_idx ? c2v_submin : c2v_min), negated when c2v_sign[k] = 1.
REQ-022 Accumulator adds SHALL saturate to [-(2^(ACC_WIDTH-1)-1), +(2^(ACC_WIDTH-1)-1)].
REQ-023 A c2v_min_idx >= ROW_WEIGHT SHALL make every column use c2v_min.
REQ-024 A message whose c2v_row was already accepted this frame SHALL be discarded and SHALL set err; it does not count toward completion.
REQ-025 After the NUM_ROWS-th distinct row is accepted, the FSM SHALL enter OUTPUT on the next edge with app_valid = 1.
REQ-026 app_llr SHALL be the accumulator converted to sign-magnitude with magnitude clipped to 2^(LLR_WIDTH-1)-1; zero SHALL be output with sign 0.
REQ-027 hard_dec[k] SHALL equal the accumulator sign bit; app_llr and hard_dec SHALL hold stable while app_valid & !app_ready.
REQ-028 On app_valid & app_ready the FSM SHALL return to IDLE and pulse done for exactly one cycle.
REQ-029 busy SHALL be 1 in ACCUM and OUTPUT.
REQ-030 err SHALL clear only on reset or on an accepted start.

Reset
REQ-031 rst_n low SHALL force IDLE, clear accumulators, row bitmap, app_valid, done, err, busy, and drive app_llr and hard_dec to 0, at any time including mid-frame.

Configuration
REQ-032 With LDPC_VNU_NMS_EN defined, each expanded magnitude m SHALL be scaled to m - (m >> 2) (normalized min-sum, 0.75) before the add.
REQ-033 Without LDPC_VNU_NMS_EN, magnitudes SHALL be added unscaled.

Structure
REQ-034 LLR_WIDTH, ACC_WIDTH, NUM_ROWS, ROW_WEIGHT defaults and FSM state encodings SHALL live in shared package ldpc_pkg.
REQ-035 Per-column expand/scale/saturating-add logic SHALL be sub-module ldpc_vnu_sat_add, instantiated ROW_WEIGHT times.

Verification
REQ-036 ch_llr all 8'h05, four rows each min = 3, submin = 9, min_idx = 2, signs 0 -> col 2 app_llr = 41 (0x29), others 17 (0x11); NMS_EN: col 2 = 5+4*7 = 33, others 5+4*3 = 17.
REQ-037 ch_llr all 8'h7F, four rows min = submin = 127, signs 0 -> accumulators saturate at 511, app_llr all 8'h7F, hard_dec = 0.
REQ-038 ch_llr all 8'h83 (-3), one row with c2v_sign all 1, min = 2, rest min = 0 -> app_llr all 8'h85, hard_dec = 24'hFFFFFF.
REQ-039 Row 1 sent twice, then rows 0, 2, 3 -> err = 1, app_valid asserts only after row 3, duplicate not accumulated.
REQ-040 app_ready held low 5 cycles in OUTPUT -> app_llr stable; app_ready high -> done pulses once, busy falls.
REQ-041 rst_n low after two rows accepted -> all outputs 0, IDLE; a new start runs a full frame correctly.
